mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (loads/stores).
- Serialises each 1/2/4-byte access into byte cycles and assembles or disassembles 32-bit little-endian words.
- Aborts in-flight fetches when the decode stage redirects the PC (branch_to_if path).
- Sits between if/mem stages and the RAM.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width; upper bits of the 32-bit request address are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request, level, held with if_addr_i until if_done_o
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  PC redirect; cancels a pending or in-flight fetch
- if_data_o  out  32  fetched instruction
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- mem_req_i  in  1  load/store request, level, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_addr_i  in  32  base byte address
- mem_wdata_i  in  32  store data; byte k = bits 8k+7:8k
- mem_rdata_o  out  32  load data, zero-extended raw bytes; sign-extension done in MEM
- mem_done_o  out  1  one-cycle pulse
- ram_addr_o  out  RAM_ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write data
- ram_din_i  in  8  RAM read data; valid the cycle after its address is presented

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All outputs 0; ram_wr_o = 0 mid-transaction; partial data discarded.
- States:
  - IDLE: arbitrate requests.
  - IF_RD: fetch in progress.
  - MEM_RD: load in progress.
  - MEM_WR: store in progress.
- Byte counter: N = 4 for IF; N = 1, 2 or 4 for MEM.
- Arbitration (IDLE only, registered at edge; cycle 0 = grant cycle):
  - Default priority is MEM over IF.
  - if_req_i is ignored while if_flush_i is high.
  - No grant in a cycle where if_done_o or mem_done_o is high. This is a mandatory one-cycle bubble; requesters clear req on seeing done.
- Reads:
  - Cycles 1..N: ram_addr_o = base+k-1, ram_wr_o = 0.
  - ram_din_i captured into byte k-1 in cycles 2..N+1.
  - done and data registered, high in cycle N+2; state back to IDLE in that cycle.
  - Latency: word read 6 cycles, byte read 3.
- Writes:
  - Cycles 1..N: ram_addr_o = base+k-1, ram_wr_o = 1, ram_dout_o = byte k-1.
  - mem_done_o high in cycle N+1 with ram_wr_o = 0.
  - Latency: word store 5 cycles, byte store 2.
- Outside active byte cycles: ram_wr_o = 0 and ram_addr_o holds its last value.
- Done outputs are one-cycle pulses. Data outputs hold until the next done of the same port.
- Address arithmetic is modulo 2^RAM_ADDR_W: wraps at the top of RAM, no error.
- Flush:
  - if_flush_i in any IF_RD cycle, including the cycle in which byte 3 is captured: next edge → IDLE, if_done_o suppressed, no RAM side effect.
  - Ignored in MEM_RD/MEM_WR; MEM transactions are never aborted.
- Simultaneous requests: MEM granted; IF waits in IDLE with its request held.
- Requests are not preempted once granted.
- A request dropped before done is a protocol violation; the transaction still completes.

Optional Feature:
- MEM_ARB_RR_EN
  - Defined: round-robin on simultaneous requests. A one-bit last_grant register (reset = IF) selects the port not granted last.
  - Undefined: fixed MEM-over-IF priority and no last_grant register.

Decomposition:
- Shared package/defines (defines.v):
  - state encodings.
  - mem_len codes (LenByte, LenHalf, LenWord).
  - ZeroWord / Enable / Disable.
- Sub-module mem_byte_seq: counter, address generation and byte assembly/disassembly for one transaction, driven by the arbiter FSM.

Test Plan:
- if_req_i = 1, if_addr_i = 0x100, RAM[0x100..0x103] = 13 05 00 00 → if_done_o in cycle 6, if_data_o = 0x00000513; ram_wr_o = 0 throughout.
- Store mem_len_i = 10, addr 0x200, wdata 0xDEADBEEF → ram_wr_o high in cycles 1–4 writing EF, BE, AD, DE to 0x200–0x203; mem_done_o in cycle 5.
- Load byte addr 0x203 after that store → mem_done_o in cycle 3, mem_rdata_o = 0x000000DE.
- if_req_i and mem_req_i both high in the same cycle → MEM load completes first, then a bubble cycle, then IF grant. With MEM_ARB_RR_EN and last_grant = MEM, IF is served first.
- if_flush_i pulsed in cycle 3 of a fetch → state IDLE next cycle, no if_done_o; a new fetch to 0x300 then returns RAM[0x300] correctly.
- rst low in cycle 2 of a word store → ram_wr_o drops immediately, only byte 0 written, no mem_done_o; after release, arbiter is in IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for mem_arbiter
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LenByte = 2'b00,
    LenHalf = 2'b01,
    LenWord = 2'b10
  } mem_len_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;

  // Code 11 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: len_bytes = 3'd1;
      LenHalf: len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM signal bundle for mem_arbiter
// slave modport is the arbiter side; master is the environment side.
interface mem_arbiter_if #(
  parameter int RAM_ADDR_W = 17
);
  logic                  if_req_i;
  logic [31:0]           if_addr_i;
  logic                  if_flush_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [1:0]            mem_len_i;
  logic [31:0]           mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic [31:0]           mem_rdata_o;
  logic                  mem_done_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_addr_o,
           ram_wr_o, ram_dout_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_addr_o,
           ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_byte_seq.sv
// rtl/mem_byte_seq.sv - byte counter, RAM address/data registers, word assembly
// Loaded on a grant, advanced once per byte cycle by the arbiter FSM.
module mem_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_run,
  input  logic [RAM_ADDR_W-1:0] i_base,
  input  logic [2:0]            i_nbytes,
  input  logic                  i_we,
  input  logic [31:0]           i_wdata,
  input  logic [7:0]            i_din,
  output logic [RAM_ADDR_W-1:0] o_addr,
  output logic                  o_wr,
  output logic [7:0]            o_dout,
  output logic [31:0]           o_word,
  output logic                  o_rd_last,
  output logic                  o_wr_last
);

  logic [2:0]            r_cnt;
  logic [2:0]            r_n;
  logic [RAM_ADDR_W-1:0] r_addr;
  logic                  r_wr;
  logic [7:0]            r_dout;
  logic [23:0]           r_shift;
  logic [31:0]           r_rdata;
  logic [1:0]            w_idx;
  logic                  w_more;

  assign w_idx     = 2'(r_cnt - 3'd1);
  assign w_more    = (r_cnt + 3'd1) < r_n;
  assign o_rd_last = (r_cnt == r_n);
  assign o_wr_last = (r_cnt == r_n - 3'd1);
  assign o_addr    = r_addr;
  assign o_wr      = r_wr;
  assign o_dout    = r_dout;

  // Byte k-1 arrives on i_din in byte cycle k+1, i.e. when r_cnt == k.
  always_comb begin
    o_word = r_rdata;
    if (r_cnt != 3'd0) o_word[{w_idx, 3'b000} +: 8] = i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 3'd0;
      r_n     <= 3'd4;
      r_addr  <= '0;
      r_wr    <= Disable;
      r_dout  <= 8'h00;
      r_shift <= 24'h0;
      r_rdata <= ZeroWord;
    end else if (i_start) begin
      r_cnt   <= 3'd0;
      r_n     <= i_nbytes;
      r_addr  <= i_base;
      r_wr    <= i_we;
      r_dout  <= i_wdata[7:0];
      r_shift <= i_wdata[31:8];
      r_rdata <= ZeroWord;
    end else if (i_run) begin
      r_cnt   <= r_cnt + 3'd1;
      r_rdata <= o_word;
      if (w_more) begin
        r_addr  <= r_addr + RAM_ADDR_W'(1);
        r_dout  <= r_shift[7:0];
        r_shift <= {8'h00, r_shift[23:8]};
      end else begin
        r_wr <= Disable;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM port arbiter between fetch and MEM stage
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_e                r_state, w_next;
  logic                  r_if_done, r_mem_done;
  logic [31:0]           r_if_data, r_mem_rdata;
  logic                  w_if_ok, w_bubble, w_grant_if, w_grant_mem;
  logic                  w_start, w_run, w_if_fin, w_mem_fin;
  logic                  w_rd_last, w_wr_last;
  logic [31:0]           w_word;
  logic [RAM_ADDR_W-1:0] w_base, w_seq_addr;
  logic [2:0]            w_nbytes;
  logic                  w_seq_wr;
  logic [7:0]            w_seq_dout;
  logic                  w_unused_addr_hi;

  assign w_unused_addr_hi = ^{bus.if_addr_i[31:RAM_ADDR_W], bus.mem_addr_i[31:RAM_ADDR_W]};

  assign w_if_ok  = bus.if_req_i && !bus.if_flush_i;
  assign w_bubble = r_if_done || r_mem_done;

`ifdef MEM_ARB_RR_EN
  grant_e r_last_grant;

  always_comb begin
    w_grant_mem = Disable;
    w_grant_if  = Disable;
    if (!w_bubble) begin
      if (bus.mem_req_i && w_if_ok) begin
        if (r_last_grant == GrantMem) w_grant_if  = Enable;
        else                          w_grant_mem = Enable;
      end else begin
        w_grant_mem = bus.mem_req_i;
        w_grant_if  = w_if_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_last_grant <= GrantIf;
    else if (w_start && w_grant_mem)       r_last_grant <= GrantMem;
    else if (w_start && w_grant_if)        r_last_grant <= GrantIf;
  end
`else
  always_comb begin
    w_grant_mem = Disable;
    w_grant_if  = Disable;
    if (!w_bubble) begin
      w_grant_mem = bus.mem_req_i;
      w_grant_if  = w_if_ok && !bus.mem_req_i;
    end
  end
`endif

  assign w_base   = w_grant_mem ? bus.mem_addr_i[RAM_ADDR_W-1:0] : bus.if_addr_i[RAM_ADDR_W-1:0];
  assign w_nbytes = w_grant_mem ? len_bytes(bus.mem_len_i) : 3'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = Disable;
    w_run     = Disable;
    w_if_fin  = Disable;
    w_mem_fin = Disable;
    case (r_state)
      IDLE: begin
        if (w_grant_mem) begin
          w_start = Enable;
          w_next  = bus.mem_we_i ? MEM_WR : MEM_RD;
        end else if (w_grant_if) begin
          w_start = Enable;
          w_next  = IF_RD;
        end
      end
      IF_RD: begin
        // A redirect abandons the fetch, even on its final capture cycle.
        if (bus.if_flush_i) begin
          w_next = IDLE;
        end else begin
          w_run = Enable;
          if (w_rd_last) begin
            w_if_fin = Enable;
            w_next   = IDLE;
          end
        end
      end
      MEM_RD: begin
        w_run = Enable;
        if (w_rd_last) begin
          w_mem_fin = Enable;
          w_next    = IDLE;
        end
      end
      MEM_WR: begin
        w_run = Enable;
        if (w_wr_last) begin
          w_mem_fin = Enable;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_done   <= Disable;
      r_mem_done  <= Disable;
      r_if_data   <= ZeroWord;
      r_mem_rdata <= ZeroWord;
    end else begin
      r_if_done  <= w_if_fin;
      r_mem_done <= w_mem_fin;
      if (w_if_fin) r_if_data <= w_word;
      if (w_mem_fin && r_state == MEM_RD) r_mem_rdata <= w_word;
    end
  end

  mem_byte_seq #(
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_run     (w_run),
    .i_base    (w_base),
    .i_nbytes  (w_nbytes),
    .i_we      (w_grant_mem && bus.mem_we_i),
    .i_wdata   (bus.mem_wdata_i),
    .i_din     (bus.ram_din_i),
    .o_addr    (w_seq_addr),
    .o_wr      (w_seq_wr),
    .o_dout    (w_seq_dout),
    .o_word    (w_word),
    .o_rd_last (w_rd_last),
    .o_wr_last (w_wr_last)
  );

  assign bus.if_data_o   = r_if_data;
  assign bus.if_done_o   = r_if_done;
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.mem_done_o  = r_mem_done;
  assign bus.ram_addr_o  = w_seq_addr;
  assign bus.ram_wr_o    = w_seq_wr;
  assign bus.ram_dout_o  = w_seq_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Expected orders under MEM_ARB_RR_EN follow the same macro.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic        bd_we;
  logic [16:0] bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  ram [0:131071];

  mem_arbiter_if #(.RAM_ADDR_W(17)) bus ();

  mem_arbiter #(.RAM_ADDR_W(17)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we)               ram[bd_addr] <= bd_data;
    else if (bus.ram_wr_o)   ram[bus.ram_addr_o] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd(input logic [16:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic wait_done(input bit is_mem, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if ((is_mem ? bus.mem_done_o : bus.if_done_o) === 1'b1) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic mem_start(input logic we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_len_i = len;
    bus.mem_addr_i = a; bus.mem_wdata_i = wd;
  endtask

  initial begin
    int          cyc, if_cyc, mem_cyc, exp_if_cyc, exp_mem_cyc;
    logic [31:0] wd, if_got, mem_got;
    total = 0; bad = 0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
    bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_len_i = 0;
    bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
    rst_n = 1'b0;
    #1;
    bd(17'h00100, 8'h13); bd(17'h00101, 8'h05); bd(17'h00102, 8'h00); bd(17'h00103, 8'h00);
    bd(17'h00300, 8'h37); bd(17'h00301, 8'h12); bd(17'h00302, 8'h34); bd(17'h00303, 8'h56);
    bd(17'h1FFFF, 8'hAA); bd(17'h00000, 8'h01); bd(17'h00001, 8'h02); bd(17'h00002, 8'h03);
    for (int i = 0; i < 4; i++) bd(17'h00200 + 17'(i), 8'h00);
    for (int i = 0; i < 4; i++) bd(17'h00400 + 17'(i), 8'h00);

    check("rst_if_done", 32'(bus.if_done_o), 32'h0);
    check("rst_mem_done", 32'(bus.mem_done_o), 32'h0);
    check("rst_ram_wr", 32'(bus.ram_wr_o), 32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr_o), 32'h0);
    check("rst_if_data", bus.if_data_o, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
    rst_n = 1'b1;
    step();

    // Word fetch from 0x100
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("fetch_nodone_c%0d", c), 32'(bus.if_done_o), 32'h0);
      check($sformatf("fetch_nowr_c%0d", c), 32'(bus.ram_wr_o), 32'h0);
      if (c <= 4) check($sformatf("fetch_addr_c%0d", c), 32'(bus.ram_addr_o), 32'h100 + 32'(c - 1));
    end
    step();
    check("fetch_done_c6", 32'(bus.if_done_o), 32'h1);
    check("fetch_data", bus.if_data_o, 32'h0000_0513);
    bus.if_req_i = 1'b0;
    step();
    check("fetch_done_pulse", 32'(bus.if_done_o), 32'h0);

    // Word store 0xDEADBEEF to 0x200
    wd = 32'hDEAD_BEEF;
    mem_start(1'b1, 2'b10, 32'h200, wd);
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("st_wr_c%0d", c), 32'(bus.ram_wr_o), 32'h1);
      check($sformatf("st_addr_c%0d", c), 32'(bus.ram_addr_o), 32'h200 + 32'(c - 1));
      check($sformatf("st_dout_c%0d", c), 32'(bus.ram_dout_o), 32'(wd[8*(c-1) +: 8]));
      check($sformatf("st_nodone_c%0d", c), 32'(bus.mem_done_o), 32'h0);
    end
    step();
    check("st_done_c5", 32'(bus.mem_done_o), 32'h1);
    check("st_wr_off_c5", 32'(bus.ram_wr_o), 32'h0);
    bus.mem_req_i = 1'b0;
    step();
    check("st_ram", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]}, 32'hDEAD_BEEF);
    check("st_addr_hold", 32'(bus.ram_addr_o), 32'h203);

    // Byte load from 0x203
    mem_start(1'b0, 2'b00, 32'h203, 32'h0);
    wait_done(1'b1, 10, cyc);
    check("ldb_latency", 32'(cyc), 32'd3);
    check("ldb_data", bus.mem_rdata_o, 32'h0000_00DE);
    bus.mem_req_i = 1'b0;
    step();

    // Half load from 0x201
    mem_start(1'b0, 2'b01, 32'h201, 32'h0);
    wait_done(1'b1, 10, cyc);
    check("ldh_latency", 32'(cyc), 32'd4);
    check("ldh_data", bus.mem_rdata_o, 32'h0000_ADBE);
    bus.mem_req_i = 1'b0;
    step();

    // Simultaneous word load and fetch; last grant was MEM
`ifdef MEM_ARB_RR_EN
    exp_if_cyc = 6;  exp_mem_cyc = 13;
`else
    exp_mem_cyc = 6; exp_if_cyc = 13;
`endif
    if_cyc = -1; mem_cyc = -1; if_got = '0; mem_got = '0;
    mem_start(1'b0, 2'b10, 32'h200, 32'h0);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    for (int c = 1; c <= 30 && (if_cyc < 0 || mem_cyc < 0); c++) begin
      step();
      if (bus.mem_done_o === 1'b1 && mem_cyc < 0) begin
        mem_cyc = c; mem_got = bus.mem_rdata_o; bus.mem_req_i = 1'b0;
      end
      if (bus.if_done_o === 1'b1 && if_cyc < 0) begin
        if_cyc = c; if_got = bus.if_data_o; bus.if_req_i = 1'b0;
      end
    end
    check("sim_mem_cycle", 32'(mem_cyc), 32'(exp_mem_cyc));
    check("sim_if_cycle", 32'(if_cyc), 32'(exp_if_cyc));
    check("sim_mem_data", mem_got, 32'hDEAD_BEEF);
    check("sim_if_data", if_got, 32'h0000_0513);
    step();

    // Flush in cycle 3 of a fetch, then refetch from 0x300
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    step();
    step();
    step();
    bus.if_flush_i = 1'b1; bus.if_req_i = 1'b0;
    step();
    bus.if_flush_i = 1'b0;
    check("flush_no_done", 32'(bus.if_done_o), 32'h0);
    check("flush_addr_stop", 32'(bus.ram_addr_o), 32'h102);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
    wait_done(1'b0, 12, cyc);
    check("refetch_latency", 32'(cyc), 32'd6);
    check("refetch_data", bus.if_data_o, 32'h5634_1237);
    bus.if_req_i = 1'b0;
    step();

    // Word load at top of RAM with len code 11 wraps to 0
    mem_start(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0);
    wait_done(1'b1, 10, cyc);
    check("wrap_latency", 32'(cyc), 32'd6);
    check("wrap_data", bus.mem_rdata_o, 32'h0302_01AA);
    bus.mem_req_i = 1'b0;
    step();

    // Reset in cycle 2 of a word store
    mem_start(1'b1, 2'b10, 32'h400, 32'h1122_3344);
    step();
    check("rst_st_wr_c1", 32'(bus.ram_wr_o), 32'h1);
    step();
    check("rst_st_wr_c2", 32'(bus.ram_wr_o), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_st_wr_drop", 32'(bus.ram_wr_o), 32'h0);
    check("rst_st_addr", 32'(bus.ram_addr_o), 32'h0);
    bus.mem_req_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst_st_nodone", 32'(bus.mem_done_o), 32'h0);
    check("rst_st_byte0", 32'(ram[17'h400]), 32'h44);
    check("rst_st_byte1", 32'(ram[17'h401]), 32'h00);
    mem_start(1'b0, 2'b00, 32'h400, 32'h0);
    wait_done(1'b1, 10, cyc);
    check("post_rst_latency", 32'(cyc), 32'd3);
    check("post_rst_data", bus.mem_rdata_o, 32'h0000_0044);
    bus.mem_req_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
